// File: rtl/accumulator_drain.sv
// Drains the accumulator back-buffer bank in entry order, requantizing each
// signed partial sum and streaming it out one element per valid/ready beat.
module accumulator_drain #(
  parameter int BUFFER_WIDTH           = 8,
  parameter int SMALLEST_ELEMENT_WIDTH = 4,
  localparam int IDX_W                 = $clog2(BUFFER_WIDTH),
  localparam int ACC_W                 = SMALLEST_ELEMENT_WIDTH * 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       bitwidth,
  input  logic [3:0]       shift,
  input  logic             relu_en,
  output logic [IDX_W-1:0] back_buffer_bank_entry,
  input  logic [ACC_W-1:0] back_buffer_data_read,
  output logic [7:0]       out_data,
  output logic [IDX_W-1:0] out_index,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, FLUSH = 2'd2} state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUFFER_WIDTH - 1);
  localparam logic [IDX_W-1:0] PTR_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_W:0] HI_2 = (ACC_W+1)'(32'sd1);
  localparam logic signed [ACC_W:0] LO_2 = (ACC_W+1)'(-32'sd2);
  localparam logic signed [ACC_W:0] HI_4 = (ACC_W+1)'(32'sd7);
  localparam logic signed [ACC_W:0] LO_4 = (ACC_W+1)'(-32'sd8);
  localparam logic signed [ACC_W:0] HI_8 = (ACC_W+1)'(32'sd127);
  localparam logic signed [ACC_W:0] LO_8 = (ACC_W+1)'(-32'sd128);

  // One extra bit of headroom keeps the rounding add of the most positive value from wrapping.
  function automatic logic [7:0] requant(input logic [ACC_W-1:0] x, input logic [1:0] bw,
                                         input logic [3:0] sh, input logic relu);
    logic signed [ACC_W:0] y;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] hi;
    logic signed [ACC_W:0] lo;
    y   = $signed({x[ACC_W-1], x});
    rnd = (sh == 4'd0) ? '0 : $signed({{ACC_W{1'b0}}, 1'b1} << (sh - 4'd1));
    y   = (y + rnd) >>> sh;
    y   = (relu && y[ACC_W]) ? '0 : y;
    case (bw)
      2'd1:    begin hi = HI_4; lo = LO_4; end
      2'd2:    begin hi = HI_8; lo = LO_8; end
      default: begin hi = HI_2; lo = LO_2; end
    endcase
    y = (y > hi) ? hi : ((y < lo) ? lo : y);
    return y[7:0];
  endfunction

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       bw_q, bw_d;
  logic [3:0]       sh_q, sh_d;
  logic             relu_q, relu_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Sequencer next state plus output-register loading.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    bw_d    = bw_q;
    sh_d    = sh_q;
    relu_d  = relu_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // A start coinciding with the done pulse is dropped.
        if (start && !done_q) begin
          bw_d    = bitwidth;
          sh_d    = shift;
          relu_d  = relu_en;
          ptr_d   = '0;
          busy_d  = 1'b1;
          state_d = DRAIN;
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (!valid_q || out_ready) begin
          data_d  = requant(back_buffer_data_read, bw_q, sh_q, relu_q);
          idx_d   = ptr_q;
          last_d  = (ptr_q == LAST_IDX);
          valid_d = 1'b1;
          if (ptr_q == LAST_IDX) begin
            state_d = FLUSH;
          end else begin
            ptr_d = ptr_q + PTR_ONE;
          end
        end else begin
          state_d = DRAIN;
        end
      end
      FLUSH: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = FLUSH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any drain in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      bw_q    <= 2'd0;
      sh_q    <= 4'd0;
      relu_q  <= 1'b0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      bw_q    <= bw_d;
      sh_q    <= sh_d;
      relu_q  <= relu_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign back_buffer_bank_entry = ptr_q;
  assign out_data  = data_q;
  assign out_index = idx_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_accumulator_drain.sv
// Randomized self-checking bench for accumulator_drain against an arithmetic
// reference of the requantization rules and the drain timing.
module tb_accumulator_drain;
  localparam int BW = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  bitwidth;
  logic [3:0]  shift;
  logic        relu_en;
  logic [2:0]  entry;
  logic [15:0] rd;
  logic [7:0]  out_data;
  logic [2:0]  out_index;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [15:0] bank [BW];
  int errors = 0;
  int checks = 0;

  logic [7:0] bd[$];
  int         bi[$];
  bit         bl[$];
  int         bc[$];
  int         done_cnt, done_cyc, busy_rise, stab_viol;
  bit         timeout, after_act;

  accumulator_drain #(.BUFFER_WIDTH(BW), .SMALLEST_ELEMENT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .bitwidth(bitwidth), .shift(shift),
    .relu_en(relu_en), .back_buffer_bank_entry(entry), .back_buffer_data_read(rd),
    .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always_comb rd = bank[entry];

  // Reference: round half up via floor division, ReLU, clamp to N-bit signed range.
  function automatic logic [7:0] ref_f(input logic [15:0] raw, input logic [1:0] bw,
                                       input logic [3:0] sh, input logic rl);
    int x, d, q, n, hi, lo;
    x = int'($signed(raw));
    q = x;
    if (sh != 4'd0) begin
      d = 32'sd1 << sh;
      x = x + d / 2;
      q = x / d;
      if ((x % d != 0) && (x < 0)) q = q - 1;
    end
    if (rl && q < 0) q = 0;
    n  = (bw == 2'd1) ? 4 : ((bw == 2'd2) ? 8 : 2);
    hi = (1 << (n - 1)) - 1;
    lo = -(1 << (n - 1));
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return q[7:0];
  endfunction

  task automatic rand_bank();
    for (int i = 0; i < BW; i++) bank[i] = 16'($urandom);
  endtask

  // Runs one drain starting in the current cycle and records what was observed.
  task automatic run_drain(input logic [1:0] bw, input logic [3:0] sh, input logic rl,
                           input int stall_at, input int stall_len, input bit rnd_ready,
                           input bit poke, input int tail);
    int stalled;
    bit pstall;
    logic [7:0] pd;
    logic [2:0] pi, pe;
    logic pl;
    bd.delete(); bi.delete(); bl.delete(); bc.delete();
    done_cnt = 0; done_cyc = -1; busy_rise = -1; stab_viol = 0;
    timeout = 1'b1; after_act = 1'b0; stalled = 0; pstall = 1'b0;
    pd = 8'd0; pi = 3'd0; pe = 3'd0; pl = 1'b0;
    bitwidth = bw; shift = sh; relu_en = rl; start = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      bitwidth = 2'($urandom); shift = 4'($urandom); relu_en = 1'($urandom);
      if (busy_rise < 0 && busy) busy_rise = c;
      if (pstall && (out_data !== pd || out_index !== pi || out_last !== pl ||
                     entry !== pe || out_valid !== 1'b1)) stab_viol++;
      if (done_cnt > 0 && (busy || out_valid || done)) after_act = 1'b1;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      else if (out_valid && int'(out_index) == stall_at && stalled < stall_len) begin
        out_ready = 1'b0;
        stalled++;
      end else out_ready = 1'b1;
      if (poke && (c == 4 || c == 9 || c == done_cyc)) start = 1'b1;
      if (out_valid && out_ready) begin
        bd.push_back(out_data); bi.push_back(int'(out_index));
        bl.push_back(out_last); bc.push_back(c);
      end
      pstall = out_valid && !out_ready;
      pd = out_data; pi = out_index; pl = out_last; pe = entry;
      if (done_cyc >= 0 && c >= done_cyc + tail) begin
        timeout = 1'b0;
        break;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        out_data !== 8'd0 || out_index !== 3'd0 || entry !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b last=%b busy=%b done=%b data=%h idx=%0d entry=%0d, want all 0",
               out_valid, out_last, busy, done, out_data, out_index, entry);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    rand_bank();
    bitwidth = 2'd2; shift = 4'd0; relu_en = 1'b0; start = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_drain_active: valid=%b busy=%b, want 1 1", out_valid, busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        out_data !== 8'd0 || out_index !== 3'd0 || entry !== 3'd0) begin
      errors++;
      $display("FAIL async_reset: valid=%b last=%b busy=%b done=%b data=%h idx=%0d entry=%0d, want all 0",
               out_valid, out_last, busy, done, out_data, out_index, entry);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    begin
      int act;
      act = 0;
      repeat (14) begin
        @(posedge clk); #1;
        if (done || out_valid || busy) act++;
      end
      checks++;
      if (act != 0) begin
        errors++;
        $display("FAIL no_done_after_abort: %0d active cycles, want 0", act);
      end
    end
    run_drain(2'd2, 4'd0, 1'b0, -1, 0, 1'b0, 1'b0, 1);
    checks++;
    if (timeout || bd.size() != BW) begin
      errors++;
      $display("FAIL restart_beats: %0d beats timeout=%0b, want %0d", bd.size(), timeout, BW);
    end else begin
      for (int i = 0; i < BW; i++) begin
        checks++;
        if (bi[i] != i || bd[i] !== ref_f(bank[i], 2'd2, 4'd0, 1'b0)) begin
          errors++;
          $display("FAIL restart_beat%0d: idx=%0d data=%h, want idx=%0d data=%h",
                   i, bi[i], bd[i], i, ref_f(bank[i], 2'd2, 4'd0, 1'b0));
        end
      end
    end
  endtask

  task automatic test_full_rate();
    for (int i = 0; i < BW; i++) bank[i] = 16'(i);
    run_drain(2'd2, 4'd0, 1'b0, -1, 0, 1'b0, 1'b0, 1);
    checks++;
    if (timeout || bd.size() != BW) begin
      errors++;
      $display("FAIL full_rate_beats: %0d beats timeout=%0b, want %0d", bd.size(), timeout, BW);
    end else begin
      for (int i = 0; i < BW; i++) begin
        checks++;
        if (bd[i] !== 8'(i) || bi[i] != i || bl[i] != (i == BW - 1) || bc[i] != i + 2) begin
          errors++;
          $display("FAIL full_rate_beat%0d: data=%h idx=%0d last=%0b cyc=%0d, want %h %0d %0b %0d",
                   i, bd[i], bi[i], bl[i], bc[i], 8'(i), i, (i == BW - 1), i + 2);
        end
      end
    end
    checks++;
    if (done_cnt != 1 || done_cyc != BW + 2 || busy_rise != 1) begin
      errors++;
      $display("FAIL full_rate_timing: dones=%0d done_cyc=%0d busy_cyc=%0d, want 1 %0d 1",
               done_cnt, done_cyc, busy_rise, BW + 2);
    end
  endtask

  task automatic test_rounding();
    logic [7:0] exp_s2 [2];
    logic [7:0] exp_s4 [2];
    exp_s2[0] = 8'd6;  exp_s2[1] = 8'hFA;
    exp_s4[0] = 8'h7F; exp_s4[1] = 8'h80;
    rand_bank();
    bank[0] = 16'h0017; bank[1] = 16'hFFE9; bank[2] = 16'h7FFF; bank[3] = 16'h8000;
    for (int pass = 0; pass < 2; pass++) begin
      logic [3:0] sh;
      sh = (pass == 0) ? 4'd2 : 4'd4;
      run_drain(2'd2, sh, 1'b0, -1, 0, 1'b0, 1'b0, 1);
      checks++;
      if (timeout || bd.size() != BW) begin
        errors++;
        $display("FAIL round_beats_sh%0d: %0d beats, want %0d", sh, bd.size(), BW);
      end else begin
        checks++;
        if (pass == 0 && (bd[0] !== exp_s2[0] || bd[1] !== exp_s2[1])) begin
          errors++;
          $display("FAIL round_sh2: got %h %h, want %h %h", bd[0], bd[1], exp_s2[0], exp_s2[1]);
        end else if (pass == 1 && (bd[2] !== exp_s4[0] || bd[3] !== exp_s4[1])) begin
          errors++;
          $display("FAIL round_sat_sh4: got %h %h, want %h %h", bd[2], bd[3], exp_s4[0], exp_s4[1]);
        end
        for (int i = 0; i < BW; i++) begin
          checks++;
          if (bd[i] !== ref_f(bank[i], 2'd2, sh, 1'b0)) begin
            errors++;
            $display("FAIL round_model_sh%0d_e%0d: got %h, want %h", sh, i, bd[i],
                     ref_f(bank[i], 2'd2, sh, 1'b0));
          end
        end
      end
    end
  endtask

  task automatic test_sat_relu();
    logic [7:0] exp_a [4];
    logic [7:0] exp_b [3];
    exp_a[0] = 8'h01; exp_a[1] = 8'hFE; exp_a[2] = 8'h01; exp_a[3] = 8'hFE;
    exp_b[0] = 8'h00; exp_b[1] = 8'h07; exp_b[2] = 8'h03;
    rand_bank();
    bank[0] = 16'd5; bank[1] = 16'hFFFB; bank[2] = 16'd1; bank[3] = 16'hFFFE;
    for (int pass = 0; pass < 2; pass++) begin
      logic [1:0] bw;
      bw = (pass == 0) ? 2'd0 : 2'd3;
      run_drain(bw, 4'd0, 1'b0, -1, 0, 1'b0, 1'b0, 1);
      checks++;
      if (timeout || bd.size() != BW) begin
        errors++;
        $display("FAIL sat2_beats_bw%0d: %0d beats, want %0d", bw, bd.size(), BW);
      end else begin
        for (int i = 0; i < 4; i++) begin
          checks++;
          if (bd[i] !== exp_a[i]) begin
            errors++;
            $display("FAIL sat2_bw%0d_e%0d: got %h, want %h", bw, i, bd[i], exp_a[i]);
          end
        end
      end
    end
    rand_bank();
    bank[0] = 16'hFF9C; bank[1] = 16'd9; bank[2] = 16'd3;
    run_drain(2'd1, 4'd0, 1'b1, -1, 0, 1'b0, 1'b0, 1);
    checks++;
    if (timeout || bd.size() != BW) begin
      errors++;
      $display("FAIL relu4_beats: %0d beats, want %0d", bd.size(), BW);
    end else begin
      for (int i = 0; i < BW; i++) begin
        checks++;
        if ((i < 3 && bd[i] !== exp_b[i]) || bd[i] !== ref_f(bank[i], 2'd1, 4'd0, 1'b1)) begin
          errors++;
          $display("FAIL relu4_e%0d: got %h, want %h", i, bd[i], ref_f(bank[i], 2'd1, 4'd0, 1'b1));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    rand_bank();
    run_drain(2'd2, 4'd3, 1'b0, 2, 3, 1'b0, 1'b0, 1);
    checks++;
    if (timeout || bd.size() != BW) begin
      errors++;
      $display("FAIL bp_beats: %0d beats timeout=%0b, want %0d", bd.size(), timeout, BW);
    end else begin
      for (int i = 0; i < BW; i++) begin
        checks++;
        if (bi[i] != i || bd[i] !== ref_f(bank[i], 2'd2, 4'd3, 1'b0)) begin
          errors++;
          $display("FAIL bp_beat%0d: idx=%0d data=%h, want %0d %h", i, bi[i], bd[i], i,
                   ref_f(bank[i], 2'd2, 4'd3, 1'b0));
        end
      end
      checks++;
      if (bc[2] != 7 || bc[3] != 8 || done_cyc != BW + 5) begin
        errors++;
        $display("FAIL bp_timing: beat2@%0d beat3@%0d done@%0d, want 7 8 %0d",
                 bc[2], bc[3], done_cyc, BW + 5);
      end
    end
    checks++;
    if (stab_viol != 0) begin
      errors++;
      $display("FAIL bp_stable: %0d unstable stall cycles, want 0", stab_viol);
    end
  endtask

  task automatic test_start_handling();
    rand_bank();
    run_drain(2'd2, 4'd3, 1'b0, -1, 0, 1'b0, 1'b1, 1);
    checks++;
    if (timeout || bd.size() != BW || done_cnt != 1 || after_act) begin
      errors++;
      $display("FAIL start_ignored: beats=%0d dones=%0d after=%0b timeout=%0b, want %0d 1 0 0",
               bd.size(), done_cnt, after_act, timeout, BW);
    end else begin
      for (int i = 0; i < BW; i++) begin
        checks++;
        if (bd[i] !== ref_f(bank[i], 2'd2, 4'd3, 1'b0)) begin
          errors++;
          $display("FAIL start_ignored_e%0d: got %h, want %h", i, bd[i], ref_f(bank[i], 2'd2, 4'd3, 1'b0));
        end
      end
    end
    rand_bank();
    run_drain(2'd1, 4'd0, 1'b0, -1, 0, 1'b0, 1'b0, 1);
    checks++;
    if (timeout || bd.size() != BW || busy_rise != 1) begin
      errors++;
      $display("FAIL restart_after_done: beats=%0d busy_cyc=%0d, want %0d 1", bd.size(), busy_rise, BW);
    end else begin
      for (int i = 0; i < BW; i++) begin
        checks++;
        if (bd[i] !== ref_f(bank[i], 2'd1, 4'd0, 1'b0)) begin
          errors++;
          $display("FAIL new_settings_e%0d: got %h, want %h", i, bd[i], ref_f(bank[i], 2'd1, 4'd0, 1'b0));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      logic [1:0] bw;
      logic [3:0] sh;
      logic rl;
      bw = 2'($urandom); sh = 4'($urandom); rl = 1'($urandom);
      rand_bank();
      for (int i = 0; i < BW; i++) if ($urandom_range(0, 1) == 0) bank[i] = 16'($signed(10'($urandom)));
      run_drain(bw, sh, rl, -1, 0, 1'b1, 1'b0, 1);
      checks++;
      if (timeout || bd.size() != BW || done_cnt != 1 || stab_viol != 0) begin
        errors++;
        $display("FAIL rand%0d_run: beats=%0d dones=%0d unstable=%0d timeout=%0b, want %0d 1 0 0",
                 r, bd.size(), done_cnt, stab_viol, timeout, BW);
      end else begin
        for (int i = 0; i < BW; i++) begin
          checks++;
          if (bi[i] != i || bl[i] != (i == BW - 1) || bd[i] !== ref_f(bank[i], bw, sh, rl)) begin
            errors++;
            $display("FAIL rand%0d_e%0d: idx=%0d last=%0b data=%h, want %0d %0b %h", r, i,
                     bi[i], bl[i], bd[i], i, (i == BW - 1), ref_f(bank[i], bw, sh, rl));
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; bitwidth = 2'd0; shift = 4'd0; relu_en = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < BW; i++) bank[i] = 16'd0;
    #2;
    test_reset();
    test_full_rate();
    test_rounding();
    test_sat_relu();
    test_backpressure();
    test_start_handling();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/accumulator_drain.md
Name: accumulator_drain

Overview:
- Downstream consumer of the accumulator bank's back buffer.
- After each tile `transfer`, it walks every back-buffer bank entry in order 0..BUFFER_WIDTH-1.
- Each signed partial sum is requantized (rounding right shift, optional ReLU, saturation to the active activation bitwidth) and streamed out one element per valid/ready beat to the activation writeback path.

Parameters:
- BUFFER_WIDTH, 8, number of entries in the back-buffer bank; entry index width is $clog2(BUFFER_WIDTH).
- SMALLEST_ELEMENT_WIDTH, 4, accumulator element width is SMALLEST_ELEMENT_WIDTH*4 (16 by default).

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- reset, input, 1, asynchronous, active-high reset.
- start, input, 1, single-cycle pulse to begin draining the bank; ignored while busy.
- bitwidth, input, 2, output precision: 0=2-bit, 1=4-bit, 2=8-bit, 3=treated as 2-bit. Sampled on an accepted start.
- shift, input, 4, right-shift amount 0..15. Sampled on an accepted start.
- relu_en, input, 1, clamp negatives to 0. Sampled on an accepted start.
- back_buffer_bank_entry, output, $clog2(BUFFER_WIDTH), entry index presented to the back-buffer read port.
- back_buffer_data_read, input, SMALLEST_ELEMENT_WIDTH*4, signed accumulator value for the presented entry. Combinational, valid in the same cycle.
- out_data, output, 8, requantized element, sign-extended to 8 bits.
- out_index, output, $clog2(BUFFER_WIDTH), entry index of out_data.
- out_valid, output, 1, out_data/out_index/out_last valid.
- out_ready, input, 1, consumer accepts the beat when out_valid&&out_ready.
- out_last, output, 1, high with the final entry (BUFFER_WIDTH-1).
- busy, output, 1, high from the cycle after an accepted start until done.
- done, output, 1, one-cycle pulse in the cycle after the last beat handshakes.

Behaviour:
- Reset state, asserted asynchronously:
  - FSM=IDLE, read pointer=0.
  - All outputs 0: out_valid, out_last, busy, done, out_data, out_index, back_buffer_bank_entry.
  - Reset mid-drain aborts immediately; no done pulse follows.
- FSM has three states: IDLE, DRAIN, FLUSH.
- IDLE:
  - start=1 latches bitwidth, shift and relu_en, clears the pointer, and goes to DRAIN.
  - busy rises the next cycle.
- DRAIN:
  - back_buffer_bank_entry=pointer.
  - The output register loads when (!out_valid || out_ready). On load: out_data=f(back_buffer_data_read), out_index=pointer, out_last=(pointer==BUFFER_WIDTH-1), out_valid=1, pointer++.
  - After loading entry BUFFER_WIDTH-1, go to FLUSH. The pointer does not wrap.
- FLUSH:
  - Wait for the out_last beat to handshake.
  - On handshake: out_valid=0, done=1 for one cycle, busy=0, go to IDLE.
- Output stability: while out_valid && !out_ready, out_data, out_index and out_last hold stable; the pointer and back_buffer_bank_entry hold.
- Throughput is 1 element/cycle with out_ready tied high.
- Latency: start at cycle 0, first out_valid at cycle 2, last beat at cycle BUFFER_WIDTH+1, done at cycle BUFFER_WIDTH+2.
- start during busy or FLUSH is ignored. start in the same cycle as done is ignored; start is accepted the next cycle in IDLE.
- f(x), with x signed 16-bit, computed in 17 bits signed:
  1. If shift>0: y = (x + (1<<(shift-1))) >>> shift (round half up). If shift==0: y=x.
  2. If relu_en and y<0: y=0.
  3. Saturate y to the signed range of N bits: N=2 gives [-2,1], N=4 gives [-8,7], N=8 gives [-128,127].
  4. Sign-extend the result to 8 bits.
- The +rounding of 0x7FFF must not overflow; the 17-bit intermediate is mandatory.

Test Plan:
- Reset mid-drain: assert reset in cycle 4 of a drain → all outputs 0 immediately; no done; a new start then drains entries 0..7 normally.
- Full-rate drain: bank = {0,1,2,3,4,5,6,7}, bitwidth=2, shift=0, relu off, out_ready=1 → out_data 0..7 on cycles 2..9, out_index matches, out_last only on index 7, done at cycle 10.
- Rounding/shift: entry=0x0017 (23), shift=2, bitwidth=2 → 6. Entry=0xFFE9 (-23), shift=2 → -6 (0xFA). Entry=0x7FFF, shift=4, 8-bit → 127 saturated, no wrap.
- Saturation and ReLU:
  - bitwidth=0, entries {5,-5,1,-2} → {1,-2 (0xFE),1,-2 (0xFE)}.
  - bitwidth=1, relu_en=1, entries {-100,9,3} → {0,7,3}.
  - bitwidth=3 behaves as 2-bit.
- Backpressure: out_ready low for 3 cycles while out_index=2 → out_data/out_index/back_buffer_bank_entry stable. Resumes with index 3 next; no element lost or duplicated; total 8 beats.
- Start handling: start pulsed during DRAIN and on the done cycle → ignored (exactly 8 beats, one done). start one cycle after done with new bitwidth → new settings applied to all 8 elements.
